// File: rtl/calc_disp_pkg.sv
// Shared constants and types for the calculator display reader.
// Digit font, blanking constants and the digit index type live here so
// the scanner and the segment decoder agree on a single definition.
package calc_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low "everything off" patterns for the segment and anode buses.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index of a digit slot within a scan frame, 0 = least significant.
    typedef logic [1:0] digit_idx_t;

    // Standard hex font, active-low, bit 0 = segment a .. bit 6 = segment g.
    localparam logic [6:0] HEX_FONT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Active-low anode pattern that enables exactly the given digit.
    function automatic logic [3:0] digit_enable(input digit_idx_t idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/calc_disp_hex7seg.sv
// Combinational hex-to-7-segment decoder (active-low segments).
module hex7seg
    import calc_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/calc_disp.sv
// Four-digit multiplexed hex display reader for the calculator accumulator.
// A loaded value is held pending and only committed when the scan wraps
// from digit 3 back to digit 0, so no frame mixes old and new digits.
// Optional build macro: CALC_DISP_SIGNED_EN -- show negative values as a
// magnitude with the digit-3 decimal point lit as a minus sign.
module calc_disp
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pending
);

    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    digit_idx_t       digit_idx;
    logic             scan_on;     // cleared by reset: first tick starts at digit 0
    logic [15:0]      disp_reg;
    logic [15:0]      pend_reg;

    logic             tick;
    logic             frame_wrap;
    logic             commit;
    digit_idx_t       idx_next;
    logic [15:0]      disp_next;
    logic [15:0]      show_value;
    logic [3:0]       nib_nz;
    logic [3:0]       nibble;
    logic [6:0]       font_seg;
    logic             blank_slot;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign tick       = (div_cnt == DIV_LAST);
    // The wrap 3 -> 0 is the only point where a new value may enter the display.
    assign frame_wrap = tick && scan_on && (digit_idx == digit_idx_t'(NUM_DIGITS - 1));
    assign commit     = frame_wrap && pending;
    // Straight after reset the first tick shows digit 0 rather than advancing.
    assign idx_next   = scan_on ? digit_idx_t'(digit_idx + 2'd1) : digit_idx_t'(0);
    // Decode from the value that will be on screen after this edge, so
    // digit 0 of a new frame already uses the freshly committed value.
    assign disp_next  = commit ? pend_reg : disp_reg;

`ifdef CALC_DISP_SIGNED_EN
    logic negative;
    assign negative   = disp_next[15];
    // 0x8000 negates to itself, which displays as 8000 as intended.
    assign show_value = negative ? (16'h0000 - disp_next) : disp_next;
`else
    assign show_value = disp_next;
`endif

    // Per-nibble non-zero flags feed the leading-zero blanking test.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
            assign nib_nz[gi] = |show_value[4*gi +: 4];
        end
    endgenerate

    assign nibble = show_value[{idx_next, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (font_seg)
    );

    // Slot i (i>0) is blank when it and every more significant nibble are zero.
    assign blank_slot = blank_lz && (idx_next != digit_idx_t'(0))
                        && ((nib_nz >> idx_next) == 4'b0000);

    // Next-slot anode/segment/decimal-point pattern.
    always_comb begin
        an_next  = blank_slot ? AN_OFF  : digit_enable(idx_next);
        seg_next = blank_slot ? SEG_OFF : font_seg;
        dp_next  = 1'b1;
`ifdef CALC_DISP_SIGNED_EN
        // The digit-3 slot carries the minus sign, so it stays enabled
        // even when its digit is blanked.
        if (negative && (idx_next == digit_idx_t'(NUM_DIGITS - 1))) begin
            an_next = digit_enable(idx_next);
            dp_next = 1'b0;
        end
`endif
    end

    // Prescaler: one tick every REFRESH_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit scanner and registered display outputs, updated on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx <= '0;
            scan_on   <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else if (tick) begin
            digit_idx <= idx_next;
            scan_on   <= 1'b1;
            an        <= an_next;
            seg       <= seg_next;
            dp        <= dp_next;
        end
    end

    // Frame boundary pulse and commit of the pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            disp_reg   <= '0;
        end else begin
            frame_done <= frame_wrap;
            if (commit) begin
                disp_reg <= pend_reg;
            end
        end
    end

    // Pending capture: the last load wins; a load coinciding with a commit
    // keeps the value pending for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg <= '0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                pend_reg <= value_in;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_disp.sv
// Scoreboard bench for calc_disp with REFRESH_DIV=4: the stimulus pushes the
// expected display state of every digit slot, the monitor pops and compares
// one entry after each tick edge.
module tb_calc_disp;

`ifdef CALC_DISP_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    calc_disp #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       pend;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   slot_no = 0;

    // Bench-side edge count since reset release; a tick lands every 4th edge.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_out(input string name, input logic [3:0] ea, input logic [6:0] es,
                             input logic edp, input logic efd, input logic ep);
        checks++;
        if ({an, seg, dp, frame_done, pending} !== {ea, es, edp, efd, ep}) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h dp=%b fd=%b pend=%b, expected an=%b seg=%h dp=%b fd=%b pend=%b",
                     name, an, seg, dp, frame_done, pending, ea, es, edp, efd, ep);
        end else begin
            $display("ok   %s: an=%b seg=%h dp=%b fd=%b pend=%b",
                     name, an, seg, dp, frame_done, pending);
        end
    endtask

    // Monitor: compare the slot presented after every tick edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && cyc != 0 && (cyc % 4) == 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slot: got an=%b seg=%h with no expectation queued", an, seg);
            end else begin
                e = sb.pop_front();
                check_out($sformatf("slot%0d", e.id), e.an, e.seg, e.dp, e.fd, e.pend);
            end
        end
    end

    // One digit slot: queue its expected display, optionally strobe load
    // at edge ld_at (1..4, 4 = the tick edge itself), then run to the tick.
    task automatic slot(input int ld_at, input logic [15:0] v, input logic [3:0] ea,
                        input logic [6:0] es, input logic edp, input logic efd, input logic ep);
        exp_t e;
        slot_no++;
        e.an = ea; e.seg = es; e.dp = edp; e.fd = efd; e.pend = ep; e.id = slot_no;
        sb.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            if (k == ld_at) begin
                value_in = v;
                load     = 1'b1;
            end
            @(posedge clk);
            #1 load = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_out("reset_initial", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // First tick shows digit 0 of value 0; then a 0x1234 load mid-frame.
        slot(0, 16'h0,    4'hE, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hD, 7'h40, 1, 0, 0);
        slot(2, 16'h1234, 4'hB, 7'h40, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h40, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h19, 1, 1, 0);
        slot(0, 16'h0,    4'hD, 7'h30, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h24, 1, 0, 0);
        slot(0, 16'h0,    4'h7, 7'h79, 1, 0, 0);

        // Last value wins: 0xAAAA overwritten by 0xBEEF before the wrap.
        slot(0, 16'h0,    4'hE, 7'h19, 1, 1, 0);
        slot(1, 16'hAAAA, 4'hD, 7'h30, 1, 0, 1);
        slot(3, 16'hBEEF, 4'hB, 7'h24, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h79, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h0E, 1, 1, 0);
        slot(0, 16'h0,    4'hD, 7'h06, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h06, 1, 0, 0);
        slot(0, 16'h0,    4'h7, 7'h03, 1, 0, 0);

        // Load on the wrap tick while 0x1111 is pending.
        slot(0, 16'h0,    4'hE, 7'h0E, 1, 1, 0);
        slot(1, 16'h1111, 4'hD, 7'h06, 1, 0, 1);
        slot(0, 16'h0,    4'hB, 7'h06, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h03, 1, 0, 1);
        slot(4, 16'h5555, 4'hE, 7'h79, 1, 1, 1);
        slot(0, 16'h0,    4'hD, 7'h79, 1, 0, 1);
        slot(0, 16'h0,    4'hB, 7'h79, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h79, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h12, 1, 1, 0);
        slot(0, 16'h0,    4'hD, 7'h12, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h12, 1, 0, 0);
        slot(0, 16'h0,    4'h7, 7'h12, 1, 0, 0);

        // Leading-zero blanking: 0x0005, 0x0000, 0x0100.
        blank_lz = 1'b1;
        slot(0, 16'h0,    4'hE, 7'h12, 1, 1, 0);
        slot(1, 16'h0005, 4'hD, 7'h12, 1, 0, 1);
        slot(0, 16'h0,    4'hB, 7'h12, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h12, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h12, 1, 1, 0);
        slot(1, 16'h0000, 4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);
        slot(1, 16'h0100, 4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hF, 7'h7F, 1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);
        slot(0, 16'h0,    4'hD, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h79, 1, 0, 0);
        slot(0, 16'h0,    4'hF, 7'h7F, 1, 0, 0);

        // Negative values: 0xFFFE and 0x8000 (signed build shows magnitude).
        blank_lz = 1'b0;
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);
        slot(1, 16'hFFFE, 4'hD, 7'h40, 1, 0, 1);
        slot(0, 16'h0,    4'hB, 7'h79, 1, 0, 1);
        slot(0, 16'h0,    4'h7, 7'h40, 1, 0, 1);
        slot(0, 16'h0,    4'hE, SGN ? 7'h24 : 7'h06, 1, 1, 0);
        slot(1, 16'h8000, 4'hD, SGN ? 7'h40 : 7'h0E, 1, 0, 1);
        slot(0, 16'h0,    4'hB, SGN ? 7'h40 : 7'h0E, 1, 0, 1);
        slot(0, 16'h0,    4'h7, SGN ? 7'h40 : 7'h0E, SGN ? 1'b0 : 1'b1, 0, 1);
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);
        slot(0, 16'h0,    4'hD, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'h7, 7'h00, SGN ? 1'b0 : 1'b1, 0, 0);

        // Reset mid-slot with 0x1234 pending: everything clears at once.
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);
        slot(1, 16'h1234, 4'hD, 7'h40, 1, 0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_out("reset_async", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        slot(0, 16'h0,    4'hE, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hD, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hB, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'h7, 7'h40, 1, 0, 0);
        slot(0, 16'h0,    4'hE, 7'h40, 1, 1, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d slots never presented, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_disp.md
Name: calc_disp

Overview:
- Display-side reader for the calculator's 16-bit accumulator.
- Captures a new value on a load strobe and holds it pending.
- Commits the pending value only at a scan-frame boundary, so a frame never shows a mix of old and new digits.
- Time-multiplexes four hex digits onto a common-anode, active-low 7-segment display; sits beside the accumulator/LED path in the calc top level.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz digit rate); minimum 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
value_in  input  16  accumulator value to display
load  input  1  one-cycle strobe: capture value_in into pending register
blank_lz  input  1  1 = blank leading zero digits
an  output  4  digit enables, active-low, an[0] = least significant digit
seg  output  7  segments active-low, seg[0]=a .. seg[6]=g
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when a frame boundary commits
pending  output  1  1 = value captured, not yet committed

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_done=0, pending=0; div_cnt, digit_idx, disp_reg and pend_reg all 0.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps. tick=1 when div_cnt==REFRESH_DIV-1.
- Scan: on each tick, digit_idx advances modulo 4 (3 -> 0 is the frame boundary).
- Outputs are registered and update on the tick edge to reflect the new digit_idx. Output latency from tick is 0 cycles beyond that edge.
- Load: on load=1, pend_reg<=value_in and pending<=1. A second load before commit overwrites pend_reg; the last value wins.
- Commit: on a tick where digit_idx==3:
  - frame_done<=1 for exactly one cycle.
  - If pending=1: disp_reg<=pend_reg and pending<=0.
  - Digit 0 of the new frame is decoded from the committed value on that same edge.
- Simultaneous load and commit: the old pend_reg is committed; the new value_in goes to pend_reg and pending stays 1.
- Digit decode: nibble = disp_reg[4*idx+3 : 4*idx]. Standard hex font, active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Leading-zero blanking (blank_lz=1):
  - Digit i (i=1..3) is blanked when nibbles i..3 are all zero.
  - A blanked slot drives an=4'b1111 and seg=7F.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- blank_lz is sampled combinationally on every slot.
- Reset mid-operation: all state clears immediately. Any pending value is discarded and the display restarts at digit 0 after the first tick.

Optional Feature:
- CALC_DISP_SIGNED_EN defined:
  - If disp_reg[15]=1, the digits show the 16-bit two's-complement magnitude (16'h0 - disp_reg).
  - 0x8000 shows 8000.
  - dp=0 during the digit-3 slot as a minus indicator.
  - Digit 3 stays enabled (an[3]=0) even when blanked, with seg=7F and dp lit.
- Undefined: raw hex is shown and dp is constantly 1.

Decomposition:
- Package calc_disp_pkg holds:
  - NUM_DIGITS=4, SEG_OFF=7'h7F, AN_OFF=4'hF;
  - the 16-entry HEX_FONT constant array;
  - the digit index typedef (2-bit).
- One combinational sub-module, hex7seg: 4-bit nibble in, 7-bit active-low segments out, using HEX_FONT.
- calc_disp instantiates hex7seg once on the selected nibble.

Test Plan (bench uses REFRESH_DIV=4):
1. Reset:
   - Assert rst mid-run -> an=1111, seg=7F, dp=1, pending=0 immediately.
   - Release; at the first tick (4th cycle) -> an=1110, seg=40.
2. Commit timing:
   - load 0x1234 at digit 1 -> pending=1; digits 2 and 3 still show 0.
   - At the wrap -> frame_done=1 and pending=0.
   - Slots then show an 1110/1101/1011/0111 with seg 19/30/24/79.
3. Last value wins:
   - load 0xAAAA, then 0xBEEF before the wrap -> frame shows F,E,E,b (0E,06,06,03); 0xAAAA never appears.
4. Simultaneous events:
   - load 0x5555 on the same cycle as the wrap tick, with pending holding 0x1111 -> frame shows 1111 and pending stays 1.
   - The next frame shows 5555.
5. Blanking, blank_lz=1:
   - 0x0005 -> digits 3..1 give an=1111 and seg=7F; digit 0 gives seg=12.
   - 0x0000 -> digit 0 gives seg=40.
   - 0x0100 -> digit 2 lit, digit 1 shows 40.
6. Signed (CALC_DISP_SIGNED_EN):
   - 0xFFFE -> shows 0002, with dp=0 only in the digit-3 slot.
   - 0x8000 -> shows 8000 with dp=0.
   - Without the macro, 0xFFFE -> shows FFFE and dp=1 throughout.
